// File: rtl/logical_bist_pkg.sv
// Shared types and the fixed stimulus table for the logical_unit self-test engine.
// The table is only meaningful for a 32-bit datapath.
package logical_bist_pkg;

    localparam int BIST_W     = 32;
    localparam int BIST_DEPTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    typedef struct packed {
        logic [BIST_W-1:0] a;
        logic [BIST_W-1:0] b;
        logic [1:0]        af;
        logic              i;
        logic [BIST_W-1:0] exp;
    } bist_vec_t;

    localparam bist_vec_t BIST_TABLE [BIST_DEPTH] = '{
        '{32'hAAAA5555, 32'h99996666, 2'b00, 1'b0, 32'h88884444},
        '{32'hAAAA5555, 32'h99996666, 2'b01, 1'b0, 32'hBBBB7777},
        '{32'hAAAA5555, 32'h99996666, 2'b10, 1'b0, 32'h33333333},
        '{32'hAAAA5555, 32'h99996666, 2'b11, 1'b0, 32'h44448888},
        '{32'hAAAA5555, 32'h99996666, 2'b11, 1'b1, 32'h66660000}
    };

    // Out-of-range lookups return zeros so callers can index with idx+1 freely.
    function automatic bist_vec_t bist_entry(input int k);
        bist_vec_t e;
        e = '0;
        if (k >= 0 && k < BIST_DEPTH) e = BIST_TABLE[k];
        return e;
    endfunction

    function automatic logic [BIST_W-1:0] bist_exp(input int k);
        bist_vec_t e;
        e = bist_entry(k);
        return e.exp;
    endfunction

endpackage

// File: rtl/logical_unit.sv
// Combinational logic unit: AND / OR / XOR, and for af=11 either NOR (i=0)
// or the low half of b moved into the upper half (i=1).
module logical_unit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   af,
    input  logic         i,
    output logic [N-1:0] res
);

    always_comb begin
        res = '0;
        case (af)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            default: res = i ? {b[N/2-1:0], {(N-N/2){1'b0}}} : ~(a | b);
        endcase
    end

endmodule

// File: rtl/logical_unit_bist.sv
// Self-test engine: streams the fixed vector table through a logical_unit,
// two cycles per vector (APPLY then CHECK), and records pass/fail status.
module logical_unit_bist
    import logical_bist_pkg::*;
#(
    parameter int N       = 32,
    parameter int NUM_VEC = 5,
    localparam int EW     = $clog2(NUM_VEC + 1),
    localparam int IW     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fault_inj,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [EW-1:0] err_cnt,
    output logic [IW-1:0] fail_idx,
    output logic [N-1:0]  fail_res
);

    if (N != BIST_W) begin : g_bad_width
        $error("logical_unit_bist: vector table is defined only for N=32");
    end
    if (NUM_VEC < 1 || NUM_VEC > BIST_DEPTH) begin : g_bad_depth
        $error("logical_unit_bist: NUM_VEC must be in 1..5");
    end

    bist_state_t   state, state_nxt;
    logic [IW-1:0] idx;
    logic [N-1:0]  a_q, b_q;
    logic [1:0]    af_q;
    logic          i_q;

    logic [N-1:0]  res, chk, exp_cur;
    logic          accept, last, bad;
    logic [EW-1:0] err_nxt;
    bist_vec_t     ld_vec;

    logical_unit #(.N(N)) u_lu (
        .a   (a_q),
        .b   (b_q),
        .af  (af_q),
        .i   (i_q),
        .res (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = APPLY;
                    accept    = 1'b1;
                end
            end
            APPLY:   state_nxt = CHECK;
            CHECK:   state_nxt = last ? DONE : APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    // fault_inj only matters through bad, which is qualified by CHECK.
    always_comb begin
        last    = (idx == IW'(NUM_VEC - 1));
        chk     = res ^ {{(N-1){1'b0}}, fault_inj};
        exp_cur = N'(bist_exp(int'(idx)));
        bad     = (state == CHECK) && (chk != exp_cur);
        err_nxt = err_cnt;
        if (bad && err_cnt != EW'(NUM_VEC)) err_nxt = err_cnt + EW'(1);
        ld_vec  = accept ? bist_entry(0) : bist_entry(int'(idx) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            af_q     <= '0;
            i_q      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
            fail_res <= '0;
        end else if (accept) begin
            idx      <= '0;
            a_q      <= N'(ld_vec.a);
            b_q      <= N'(ld_vec.b);
            af_q     <= ld_vec.af;
            i_q      <= ld_vec.i;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
            fail_res <= '0;
        end else if (state == CHECK) begin
            err_cnt <= err_nxt;
            if (bad && err_cnt == '0) begin
                fail_idx <= idx;
                fail_res <= chk;
            end
            if (last) begin
                done <= 1'b1;
                busy <= 1'b0;
                pass <= (err_nxt == '0);
            end else begin
                // Next vector loads on the same edge so APPLY sees it immediately.
                idx  <= idx + IW'(1);
                a_q  <= N'(ld_vec.a);
                b_q  <= N'(ld_vec.b);
                af_q <= ld_vec.af;
                i_q  <= ld_vec.i;
            end
        end
    end

endmodule

// File: tb/tb_logical_unit_bist.sv
// Scoreboard bench for logical_unit_bist: expected run status is queued at start
// and compared when done rises; busy/done timing is checked every cycle.
module tb_logical_unit_bist;

    localparam int NV = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fault_inj = 1'b0;
    logic        busy, done, pass;
    logic [2:0]  err_cnt;
    logic [2:0]  fail_idx;
    logic [31:0] fail_res;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        pass;
        logic [2:0]  err;
        logic [2:0]  fidx;
        logic [31:0] fres;
    } exp_t;

    exp_t sb[$];
    logic [31:0] vexp [NV] = '{32'h88884444, 32'hBBBB7777, 32'h33333333,
                               32'h44448888, 32'h66660000};

    logical_unit_bist #(.N(32), .NUM_VEC(NV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fault_inj (fault_inj),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_idx  (fail_idx),
        .fail_res  (fail_res)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [NV-1:0] fmask);
        exp_t e;
        e.pass = 1'b1; e.err = '0; e.fidx = '0; e.fres = '0;
        for (int j = 0; j < NV; j++) begin
            if (fmask[j]) begin
                if (e.err == 0) begin
                    e.fidx = 3'(j);
                    e.fres = vexp[j] ^ 32'h1;
                end
                e.err  = e.err + 3'd1;
                e.pass = 1'b0;
            end
        end
        sb.push_back(e);
    endtask

    // One full run: start accepted on the first edge, fault applied per CHECK slot.
    task automatic run(input string name, input logic [NV-1:0] fmask,
                       input bit hold, input bit extra);
        exp_t e;
        start = 1'b1;
        push_expected(hold ? {NV{1'b1}} : fmask);
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 3'd0 || fail_res !== 32'd0) begin
            failures++;
            $display("FAIL %s_accept: busy=%b done=%b err=%0d fres=%h, want busy=1 done=0 err=0 fres=0",
                     name, busy, done, err_cnt, fail_res);
        end
        for (int c = 1; c <= 2*NV; c++) begin
            if (hold)          fault_inj = 1'b1;
            else if (c % 2 == 0) fault_inj = fmask[c/2-1];
            else               fault_inj = 1'b0;
            start = (extra && c == 3);
            tick;
            start = 1'b0;
            if (c < 2*NV) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy_c%0d: busy=%b done=%b, want busy=1 done=0", name, c, busy, done);
                end
            end
        end
        fault_inj = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: busy=%b done=%b, want busy=0 done=1", name, busy, done);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: scoreboard empty at done", name);
        end else begin
            e = sb.pop_front();
            if (pass !== e.pass || err_cnt !== e.err || fail_idx !== e.fidx || fail_res !== e.fres) begin
                failures++;
                $display("FAIL %s_status: pass=%b err=%0d fidx=%0d fres=%h, want pass=%b err=%0d fidx=%0d fres=%h",
                         name, pass, err_cnt, fail_idx, fail_res, e.pass, e.err, e.fidx, e.fres);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0 ||
            fail_idx !== 3'd0 || fail_res !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b pass=%b err=%0d fidx=%0d fres=%h, want all 0",
                     busy, done, pass, err_cnt, fail_idx, fail_res);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_clean_run;
        run("clean", 5'b00000, 1'b0, 1'b0);
        tick; tick;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: done=%b pass=%b busy=%b, want 1 1 0", done, pass, busy);
        end
    endtask

    task automatic test_single_fault;
        run("fault_idx2", 5'b00100, 1'b0, 1'b0);
        run("fault_idx4", 5'b10000, 1'b0, 1'b0);
        run("fault_1_3", 5'b01010, 1'b0, 1'b0);
    endtask

    task automatic test_fault_hold;
        run("fault_hold", 5'b00000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run("extra_start", 5'b00000, 1'b0, 1'b1);
        run("restart_a", 5'b00100, 1'b0, 1'b0);
        run("restart_b", 5'b00100, 1'b0, 1'b0);
    endtask

    task automatic test_midrun_reset;
        start = 1'b1;
        push_expected({NV{1'b1}});
        tick;
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            fault_inj = 1'b1;
            tick;
        end
        checks++;
        if (err_cnt !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: err=%0d busy=%b, want err=3 busy=1", err_cnt, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0 ||
            fail_idx !== 3'd0 || fail_res !== 32'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b pass=%b err=%0d fidx=%0d fres=%h, want all 0",
                     busy, done, pass, err_cnt, fail_idx, fail_res);
        end
        sb.delete();
        tick;
        fault_inj = 1'b0;
        rst_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run("after_reset", 5'b00000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_clean_run;
        test_single_fault;
        test_fault_hold;
        test_back_to_back;
        test_midrun_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
